ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 118 +++++++++++
 tb/tb_ram_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: streams program bytes from a valid/ready source into RAM addresses 0..LAST_ADDR.
// Revision: 1.0
`default_nettype none

module ram_loader #(
    parameter logic [3:0] LAST_ADDR = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       program_mode,
    output logic [3:0] addr_in_manual,
    output logic [7:0] data_in_manual,
    output logic       load_manual,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_WRITE  = 3'd2,
        S_SETTLE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_byte_ready;
    logic       r_program_mode;
    logic [3:0] r_addr;
    logic [7:0] r_data;
    logic       r_load;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_checksum;

    // Every output is a flop set on entry to the state that owns it, so the
    // RAM sees clean strobes and program_mode never dips between writes.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state        <= S_IDLE;
            r_byte_ready   <= 1'b0;
            r_program_mode <= 1'b0;
            r_addr         <= 4'h0;
            r_data         <= 8'h00;
            r_load         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_checksum     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_WAIT;
                        r_addr         <= 4'h0;
                        r_checksum     <= 8'h00;
                        r_byte_ready   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_program_mode <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (byte_valid) begin
                        r_state      <= S_WRITE;
                        r_data       <= byte_in;
                        r_checksum   <= r_checksum + byte_in;
                        r_byte_ready <= 1'b0;
                        r_load       <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_SETTLE;
                    r_load  <= 1'b0;
                end
                S_SETTLE: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_WAIT;
                        r_addr       <= r_addr + 4'd1;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state        <= S_IDLE;
                    r_done         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_program_mode <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_byte_ready   <= 1'b0;
                    r_program_mode <= 1'b0;
                    r_load         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready     = r_byte_ready;
    assign program_mode   = r_program_mode;
    assign addr_in_manual = r_addr;
    assign data_in_manual = r_data;
    assign load_manual    = r_load;
    assign busy           = r_busy;
    assign done           = r_done;
    assign checksum       = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed self-checking bench for ram_loader (full-range and single-address builds).
// Revision: 1.0
`default_nettype none

module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr, start, byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready, program_mode, load_manual, busy, done;
    logic [3:0] addr_in_manual;
    logic [7:0] data_in_manual, checksum;

    logic       start0, byte_valid0;
    logic [7:0] byte_in0;
    logic       byte_ready0, program_mode0, load_manual0, busy0, done0;
    logic [3:0] addr_in_manual0;
    logic [7:0] data_in_manual0, checksum0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] q_addr[$];
    logic [7:0] q_data[$];
    int         done_cnt = 0;
    int         stab_bad = 0;
    logic       prev_load = 1'b0;

    always #5 clk = ~clk;

    ram_loader #(.LAST_ADDR(4'hF)) dut (
        .clk(clk), .clr(clr), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .program_mode(program_mode), .addr_in_manual(addr_in_manual),
        .data_in_manual(data_in_manual), .load_manual(load_manual), .busy(busy), .done(done),
        .checksum(checksum)
    );

    ram_loader #(.LAST_ADDR(4'h0)) dut0 (
        .clk(clk), .clr(clr), .start(start0), .byte_in(byte_in0), .byte_valid(byte_valid0),
        .byte_ready(byte_ready0), .program_mode(program_mode0), .addr_in_manual(addr_in_manual0),
        .data_in_manual(data_in_manual0), .load_manual(load_manual0), .busy(busy0), .done(done0),
        .checksum(checksum0)
    );

    // Strobe log for the full-range loader; also flags address/data moving during SETTLE.
    always @(negedge clk) begin
        if (prev_load && q_addr.size() > 0) begin
            if (addr_in_manual !== q_addr[$] || data_in_manual !== q_data[$]) stab_bad++;
        end
        if (load_manual) begin
            q_addr.push_back(addr_in_manual);
            q_data.push_back(data_in_manual);
        end
        if (done) done_cnt++;
        prev_load = load_manual;
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        done_cnt = 0;
        stab_bad = 0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        start0 = 1'b0; byte_valid0 = 1'b0; byte_in0 = 8'h00;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if ({byte_ready, program_mode, load_manual, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {byte_ready, program_mode, load_manual, busy, done});
        end
        n_checks++;
        if (addr_in_manual !== 4'h0 || data_in_manual !== 8'h00 || checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h sum=%h want 0/00/00", addr_in_manual, data_in_manual, checksum);
        end
    endtask

    // Runs a full 16-byte load. noise=1 drives start and a junk byte while not in WAIT.
    task automatic run_seq(input logic [7:0] base, input bit incr, input bit noise, output int cyc, output int pm_bad);
        int idx;
        idx = 0; cyc = 0; pm_bad = 0;
        clear_log();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; byte_valid = 1'b1;
        while (!done && cyc < 400) begin
            if (!program_mode) pm_bad++;
            if (byte_ready) begin
                byte_in = incr ? base + 8'(idx) : base;
                idx++;
                start = 1'b0;
            end else if (noise) begin
                byte_in = 8'hEE;
                start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_run(input string name, input logic [7:0] base, input bit incr, input logic [7:0] exp_sum, input int cyc, input int pm_bad);
        int bad;
        n_checks++;
        if (cyc !== 48) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles want 48", name, cyc);
        end
        n_checks++;
        if (q_addr.size() !== 16) begin
            n_fail++;
            $display("FAIL %s_strobes: got %0d want 16", name, q_addr.size());
        end
        bad = 0;
        for (int i = 0; i < q_addr.size() && i < 16; i++) begin
            if (q_addr[i] !== 4'(i) || q_data[i] !== (incr ? base + 8'(i) : base)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_content: got %0d bad entries want 0", name, bad);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt);
        end
        n_checks++;
        if (checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL %s_checksum: got %h want %h", name, checksum, exp_sum);
        end
        n_checks++;
        if (pm_bad != 0 || stab_bad != 0 || busy !== 1'b0 || program_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_modes: got pm_drop=%0d unstable=%0d busy=%b pm=%b want 0 0 0 0", name, pm_bad, stab_bad, busy, program_mode);
        end
    endtask

    task automatic test_full_run();
        int cyc, pm_bad;
        run_seq(8'h00, 1'b1, 1'b0, cyc, pm_bad);
        check_run("full", 8'h00, 1'b1, 8'h78, cyc, pm_bad);
    endtask

    task automatic test_gapped();
        int not_ready;
        clear_log();
        not_ready = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        byte_in = 8'h0A; byte_valid = 1'b1;
        @(negedge clk); byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (byte_ready !== 1'b1) not_ready++;
            @(negedge clk);
        end
        n_checks++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL gap_ready: got %0d low cycles want 0", not_ready);
        end
        byte_in = 8'h1B; byte_valid = 1'b1;
        @(negedge clk); byte_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (q_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL gap_strobes: got %0d want 2", q_addr.size());
        end else begin
            n_checks++;
            if (q_addr[0] !== 4'h0 || q_data[0] !== 8'h0A || q_addr[1] !== 4'h1 || q_data[1] !== 8'h1B) begin
                n_fail++;
                $display("FAIL gap_content: got %h:%h %h:%h want 0:0a 1:1b", q_addr[0], q_data[0], q_addr[1], q_data[1]);
            end
        end
        n_checks++;
        if (checksum !== 8'h25 || addr_in_manual !== 4'h2 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_state: got sum=%h addr=%h ready=%b want 25 2 1", checksum, addr_in_manual, byte_ready);
        end
        do_clr();
    endtask

    task automatic test_ignore_noise();
        int cyc, pm_bad;
        run_seq(8'h31, 1'b1, 1'b1, cyc, pm_bad);
        check_run("noise", 8'h31, 1'b1, 8'h88, cyc, pm_bad);
    endtask

    task automatic test_clr_write();
        int cyc;
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; byte_valid = 1'b1; byte_in = 8'h00;
        while (!(load_manual && addr_in_manual == 4'h5) && cyc < 100) begin
            if (byte_ready) byte_in = 8'(addr_in_manual) + 8'h01;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 100) begin
            n_fail++;
            $display("FAIL clr_reach_addr5: got timeout want write at address 5");
        end
        clr = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if ({byte_ready, program_mode, load_manual, busy, done} !== 5'b0 ||
            addr_in_manual !== 4'h0 || data_in_manual !== 8'h00 || checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_mid: got ctrl=%b addr=%h data=%h sum=%h want 00000/0/00/00",
                     {byte_ready, program_mode, load_manual, busy, done}, addr_in_manual, data_in_manual, checksum);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (addr_in_manual !== 4'h0 || checksum !== 8'h00 || byte_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_restart: got addr=%h sum=%h ready=%b busy=%b want 0 00 1 1", addr_in_manual, checksum, byte_ready, busy);
        end
        do_clr();
    endtask

    task automatic test_last_addr0();
        int cyc, strobes, load_cyc, done_cyc, dones;
        logic [3:0] s_addr;
        logic [7:0] s_data;
        cyc = 0; strobes = 0; load_cyc = -1; done_cyc = -1; dones = 0;
        s_addr = 4'hX; s_data = 8'hXX;
        @(negedge clk); start0 = 1'b1; byte_in0 = 8'hFF; byte_valid0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        while (cyc < 12) begin
            if (load_manual0) begin strobes++; load_cyc = cyc; s_addr = addr_in_manual0; s_data = data_in_manual0; end
            if (done0) begin dones++; done_cyc = cyc; end
            @(negedge clk);
            cyc++;
        end
        byte_valid0 = 1'b0;
        n_checks++;
        if (strobes !== 1 || s_addr !== 4'h0 || s_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL last0_strobe: got %0d strobes addr=%h data=%h want 1 0 ff", strobes, s_addr, s_data);
        end
        n_checks++;
        if (dones !== 1 || done_cyc !== load_cyc + 2) begin
            n_fail++;
            $display("FAIL last0_done: got %0d pulses at %0d want 1 at %0d", dones, done_cyc, load_cyc + 2);
        end
        n_checks++;
        if (checksum0 !== 8'hFF || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL last0_checksum: got sum=%h busy=%b want ff 0", checksum0, busy0);
        end
    endtask

    task automatic test_wrap_aa();
        int cyc, pm_bad;
        run_seq(8'hAA, 1'b0, 1'b0, cyc, pm_bad);
        check_run("wrap", 8'hAA, 1'b0, 8'hA0, cyc, pm_bad);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_gapped();
        test_ignore_noise();
        test_clr_write();
        test_last_addr0();
        test_wrap_aa();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
